// File: rtl/control_unit_pkg.sv
// ---------------------------------------------------------------------------
// control_unit_pkg
// Shared definitions for the 8-bit accumulator CPU control sequencer and its
// datapath: bus source selects, ALU operation codes, opcodes, register-group
// sub-op bits, sequencer state encoding and the bundled control word.
// Helper functions classify an instruction (register sub-op kind, index of
// its last execute cycle, ALU code for the memory-operand group).
// ---------------------------------------------------------------------------
package control_unit_pkg;

    // Sequencer states. The encoding is visible on the debug state port.
    typedef enum logic [3:0] {
        S_CLR    = 4'd0,
        S_HALT   = 4'd1,
        S_FETCH0 = 4'd2,
        S_FETCH1 = 4'd3,
        S_FETCH2 = 4'd4,
        S_DECODE = 4'd5,
        S_EX0    = 4'd6,
        S_EX1    = 4'd7,
        S_EX2    = 4'd8,
        S_EX3    = 4'd9
    } state_t;

    // Bus source selects
    localparam logic [2:0] BUS_ZERO  = 3'd0;
    localparam logic [2:0] BUS_AR    = 3'd1;
    localparam logic [2:0] BUS_PC    = 3'd2;
    localparam logic [2:0] BUS_DR    = 3'd3;
    localparam logic [2:0] BUS_AC    = 3'd4;
    localparam logic [2:0] BUS_IR    = 3'd5;
    localparam logic [2:0] BUS_ZERO2 = 3'd6;
    localparam logic [2:0] BUS_MEM   = 3'd7;

    // ALU operation codes
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_CMA  = 3'b010;
    localparam logic [2:0] ALU_PASS = 3'b100;

    // Opcodes, IR[7:5]
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_INM = 3'd5;
    localparam logic [2:0] OP_REG = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    // Register-group sub-op bit positions within IR[3:0]
    localparam int REG_CLA = 0;
    localparam int REG_INC = 1;
    localparam int REG_CMA = 2;

    typedef enum logic [1:0] {
        RK_NOP = 2'd0,
        RK_CLA = 2'd1,
        RK_CMA = 2'd2,
        RK_INC = 2'd3
    } reg_kind_t;

    // One registered control word; every field maps straight onto a port.
    typedef struct packed {
        logic       ld_pc;
        logic       ld_ar;
        logic       ld_dr;
        logic       ld_ac;
        logic       ld_ir;
        logic       inc_pc;
        logic       inc_ar;
        logic       inc_dr;
        logic       inc_ac;
        logic       inc_ir;
        logic       clr_pc;
        logic       clr_ar;
        logic       clr_dr;
        logic       clr_ac;
        logic       clr_ir;
        logic       rd;
        logic       wr;
        logic [2:0] bus;
        logic [2:0] alu;
        logic       halted;
        logic       done;
    } ctrl_t;

    // Only one register sub-op runs: CLA beats CMA beats INC.
    function automatic reg_kind_t reg_kind(input logic [2:0] sub);
        reg_kind_t k;
        if (sub[REG_CLA])      k = RK_CLA;
        else if (sub[REG_CMA]) k = RK_CMA;
        else if (sub[REG_INC]) k = RK_INC;
        else                   k = RK_NOP;
        return k;
    endfunction

    // Index (0..3) of the final execute cycle for an instruction.
    function automatic logic [1:0] last_ex(input logic [2:0] op, input logic [2:0] sub);
        logic [1:0] n;
        case (op)
            OP_AND, OP_ADD, OP_LDA, OP_INM: n = 2'd3;
            OP_REG:  n = (reg_kind(sub) == RK_CMA) ? 2'd1 : 2'd0;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // ALU code for the memory-operand group; LDA passes DR straight through.
    function automatic logic [2:0] alu_for_op(input logic [2:0] op);
        logic [2:0] a;
        case (op)
            OP_ADD:  a = ALU_ADD;
            OP_LDA:  a = ALU_PASS;
            default: a = ALU_AND;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Hardwired Moore sequencer for the 8-bit accumulator CPU. Walks
// CLR/HALT -> FETCH0..2 -> DECODE -> EX0..EX3 and drives every datapath
// control from a registered control word that always matches the current
// state.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high; forces CLR
//   run            level; in HALT a 1 starts fetch at the current PC
//   IR[7:0]        instruction register: [7:5] opcode, [4] ignored, [3:0] addr/subop
//   load*/inc*/clear*  per-register load / increment / clear for PC AR DR AC IR
//   read, write    memory read strobe, memory write of the bus at AR
//   busSelectors   bus source (see BUS_* in control_unit_pkg)
//   aluOpcode      ALU operation (see ALU_* in control_unit_pkg)
//   halted         high while in HALT
//   instr_done     one-cycle pulse in the last cycle of each instruction
//   state          current state encoding, debug only
// ---------------------------------------------------------------------------
module control_unit
    import control_unit_pkg::*;
#(
    parameter bit START_ON_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] IR,
    output logic       loadPC,
    output logic       loadAR,
    output logic       loadDR,
    output logic       loadAC,
    output logic       loadIR,
    output logic       incPC,
    output logic       incAR,
    output logic       incDR,
    output logic       incAC,
    output logic       incIR,
    output logic       clearPC,
    output logic       clearAR,
    output logic       clearDR,
    output logic       clearAC,
    output logic       clearIR,
    output logic       read,
    output logic       write,
    output logic [2:0] busSelectors,
    output logic [2:0] aluOpcode,
    output logic       halted,
    output logic       instr_done,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_nxt;
    ctrl_t      ctrl_q;
    logic [2:0] op_q;
    logic [2:0] sub_q;
    logic [2:0] op_cur;
    logic [2:0] sub_cur;
    logic [1:0] last_q;
    state_t     end_state;
    logic       unused_ir;

    // IR[4] is reserved and IR[3] selects no register sub-op.
    assign unused_ir = ^IR[4:3];

    // The opcode is captured in DECODE; the transition into EX0 must already
    // see it, so the live IR is used while DECODE is the current state.
    assign op_cur  = (state_q == S_DECODE) ? IR[7:5] : op_q;
    assign sub_cur = (state_q == S_DECODE) ? IR[2:0] : sub_q;

    assign last_q    = last_ex(op_q, sub_q);
    assign end_state = (op_q == OP_HLT) ? S_HALT : S_FETCH0;

    // Control word for a given state and instruction.
    function automatic ctrl_t decode_outputs(input state_t s, input logic [2:0] op,
                                             input logic [2:0] sub);
        ctrl_t      c;
        reg_kind_t  rk;
        logic       is_ex;
        logic [1:0] idx;
        c     = '0;
        rk    = reg_kind(sub);
        is_ex = 1'b0;
        idx   = 2'd0;
        case (s)
            S_CLR: begin
                c.clr_pc = 1'b1;
                c.clr_ar = 1'b1;
                c.clr_dr = 1'b1;
                c.clr_ac = 1'b1;
                c.clr_ir = 1'b1;
            end
            S_HALT: c.halted = 1'b1;
            S_FETCH0: begin
                c.bus   = BUS_PC;
                c.ld_ar = 1'b1;
            end
            S_FETCH1: begin
                c.rd     = 1'b1;
                c.inc_pc = 1'b1;
            end
            S_FETCH2: begin
                c.bus   = BUS_MEM;
                c.ld_ir = 1'b1;
            end
            S_DECODE: begin
                c.bus   = BUS_IR;
                c.ld_ar = 1'b1;
            end
            S_EX0: begin
                is_ex = 1'b1;
                idx   = 2'd0;
                case (op)
                    OP_AND, OP_ADD, OP_LDA, OP_INM: c.rd = 1'b1;
                    OP_STA: begin
                        c.bus = BUS_AC;
                        c.wr  = 1'b1;
                    end
                    OP_BUN: begin
                        c.bus   = BUS_IR;
                        c.ld_pc = 1'b1;
                    end
                    OP_REG: begin
                        case (rk)
                            RK_CLA:  c.clr_ac = 1'b1;
                            RK_INC:  c.inc_ac = 1'b1;
                            RK_CMA:  c.alu    = ALU_CMA;
                            default: c.alu    = ALU_AND;
                        endcase
                    end
                    default: c.rd = 1'b0;
                endcase
            end
            S_EX1: begin
                is_ex = 1'b1;
                idx   = 2'd1;
                case (op)
                    OP_AND, OP_ADD, OP_LDA, OP_INM: begin
                        c.bus   = BUS_MEM;
                        c.ld_dr = 1'b1;
                    end
                    OP_REG: begin
                        c.alu   = ALU_CMA;
                        c.ld_ac = 1'b1;
                    end
                    default: c.ld_dr = 1'b0;
                endcase
            end
            S_EX2: begin
                is_ex = 1'b1;
                idx   = 2'd2;
                case (op)
                    OP_AND, OP_ADD, OP_LDA: c.alu = alu_for_op(op);
                    OP_INM:  c.inc_dr = 1'b1;
                    default: c.inc_dr = 1'b0;
                endcase
            end
            S_EX3: begin
                is_ex = 1'b1;
                idx   = 2'd3;
                case (op)
                    // ALU output is registered: the op was already presented in EX2.
                    OP_AND, OP_ADD, OP_LDA: begin
                        c.alu   = alu_for_op(op);
                        c.ld_ac = 1'b1;
                    end
                    OP_INM: begin
                        c.bus = BUS_DR;
                        c.wr  = 1'b1;
                    end
                    default: c.ld_ac = 1'b0;
                endcase
            end
            default: c = '0;
        endcase
        c.done = is_ex && (idx == last_ex(op, sub));
        return c;
    endfunction

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_CLR:    state_nxt = START_ON_RESET ? S_FETCH0 : S_HALT;
            S_HALT:   state_nxt = run ? S_FETCH0 : S_HALT;
            S_FETCH0: state_nxt = S_FETCH1;
            S_FETCH1: state_nxt = S_FETCH2;
            S_FETCH2: state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EX0;
            S_EX0:    state_nxt = (last_q == 2'd0) ? end_state : S_EX1;
            S_EX1:    state_nxt = (last_q == 2'd1) ? end_state : S_EX2;
            S_EX2:    state_nxt = (last_q == 2'd2) ? end_state : S_EX3;
            S_EX3:    state_nxt = end_state;
            default:  state_nxt = S_CLR;
        endcase
    end

    // Control word is computed for the state being entered so that it is
    // registered in lockstep with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_CLR;
            ctrl_q  <= decode_outputs(S_CLR, OP_AND, 3'd0);
        end else begin
            state_q <= state_nxt;
            ctrl_q  <= decode_outputs(state_nxt, op_cur, sub_cur);
        end
        if (state_q == S_DECODE) begin
            op_q  <= IR[7:5];
            sub_q <= IR[2:0];
        end
    end

    assign loadPC       = ctrl_q.ld_pc;
    assign loadAR       = ctrl_q.ld_ar;
    assign loadDR       = ctrl_q.ld_dr;
    assign loadAC       = ctrl_q.ld_ac;
    assign loadIR       = ctrl_q.ld_ir;
    assign incPC        = ctrl_q.inc_pc;
    assign incAR        = ctrl_q.inc_ar;
    assign incDR        = ctrl_q.inc_dr;
    assign incAC        = ctrl_q.inc_ac;
    assign incIR        = ctrl_q.inc_ir;
    assign clearPC      = ctrl_q.clr_pc;
    assign clearAR      = ctrl_q.clr_ar;
    assign clearDR      = ctrl_q.clr_dr;
    assign clearAC      = ctrl_q.clr_ac;
    assign clearIR      = ctrl_q.clr_ir;
    assign read         = ctrl_q.rd;
    assign write        = ctrl_q.wr;
    assign busSelectors = ctrl_q.bus;
    assign aluOpcode    = ctrl_q.alu;
    assign halted       = ctrl_q.halted;
    assign instr_done   = ctrl_q.done;
    assign state        = state_q;

endmodule
